bird_motion_ctrl: RTL and testbench

Parametrised next-generation bird physics engine for the flappy-bird game. It keeps position in fixed-point sub-pixels and uses an explicit 4-state game FSM: IDLE, PLAY, FALL (dying drop) and OVER. Flap requests are edge-detected and latched between physics ticks, and an external `hit` from pipe-collision logic is accepted. It sits between the button debouncer and the renderer/score logic, driving `bird_y` and `alive` as before.

---
 rtl/bird_pkg.sv | 30 +++
 rtl/bird_if.sv | 25 ++
 rtl/phys_tick_gen.sv | 33 +++
 rtl/bird_motion_ctrl.sv | 177 +++++++++++++++++
 tb/tb_bird_motion_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/bird_pkg.sv
// Shared definitions for the bird physics engine: state encoding, screen
// geometry and default physics constants.
package bird_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_PLAY = 2'd1;
    localparam state_t ST_FALL = 2'd2;
    localparam state_t ST_OVER = 2'd3;

    localparam int SCREEN_H    = 480;
    localparam int BIRD_SIZE   = 32;
    localparam int FLOOR_Y_DEF = SCREEN_H - BIRD_SIZE;

    localparam int Y_W_DEF      = 10;
    localparam int FRAC_DEF     = 2;
    localparam int V_W_DEF      = 10;
    localparam int TICK_DIV_DEF = 1048576;
    localparam int START_Y_DEF  = 200;
    localparam int CEIL_Y_DEF   = 0;
    localparam int GRAVITY_DEF  = 8;
    localparam int FLAP_VEL_DEF = -40;
    localparam int MAX_FALL_DEF = 20;

    function automatic logic is_alive(input state_t s);
        return (s == ST_PLAY);
    endfunction

endpackage

// File: rtl/bird_if.sv
// Bundle between the bird engine, the button/collision inputs and the
// renderer/score consumers.
interface bird_if import bird_pkg::*; #(
    parameter int Y_W = Y_W_DEF,
    parameter int V_W = V_W_DEF
);
    logic                  flap_btn;
    logic                  hit;
    logic [Y_W-1:0]        bird_y;
    logic signed [V_W-1:0] velocity;
    logic                  alive;
    state_t                state;
    logic                  tick;
    logic                  game_over;

    modport master (
        output flap_btn, hit,
        input  bird_y, velocity, alive, state, tick, game_over
    );

    modport slave (
        input  flap_btn, hit,
        output bird_y, velocity, alive, state, tick, game_over
    );
endinterface

// File: rtl/phys_tick_gen.sv
// Free-running divider; tick is a registered pulse aligned with the last
// count of each period (count == TICK_DIV-1).
module phys_tick_gen #(
    parameter int TICK_DIV = 1048576
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] PRE  = CNT_W'(TICK_DIV - 2);

    logic [CNT_W-1:0] cnt_r;
    logic             tick_r;

    // Period counter; tick is raised one count early so it lines up with LAST.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r  <= {CNT_W{1'b0}};
            tick_r <= 1'b0;
        end else begin
            if (cnt_r == LAST) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            tick_r <= (cnt_r == PRE);
        end
    end

    assign tick = tick_r;
endmodule

// File: rtl/bird_motion_ctrl.sv
// Bird physics engine: fixed-point position/velocity with a four-state game
// FSM, latched flap/hit events and updates only on physics ticks.
module bird_motion_ctrl import bird_pkg::*; #(
    parameter int Y_W      = Y_W_DEF,
    parameter int FRAC     = FRAC_DEF,
    parameter int V_W      = V_W_DEF,
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int START_Y  = START_Y_DEF,
    parameter int CEIL_Y   = CEIL_Y_DEF,
    parameter int FLOOR_Y  = FLOOR_Y_DEF,
    parameter int GRAVITY  = GRAVITY_DEF,
    parameter int FLAP_VEL = FLAP_VEL_DEF,
    parameter int MAX_FALL = MAX_FALL_DEF
) (
    input  logic   clk,
    input  logic   reset,
    bird_if.slave  bus
);
    localparam int P_W = Y_W + FRAC;
    localparam int S_W = Y_W + FRAC + 2;
    localparam logic signed [S_W-1:0] FLOOR_S = S_W'(FLOOR_Y << FRAC);
    localparam logic signed [S_W-1:0] CEIL_S  = S_W'(CEIL_Y << FRAC);
    localparam logic [P_W-1:0]        START_P = P_W'(START_Y << FRAC);
    localparam logic signed [V_W-1:0] FLAP_V  = V_W'(FLAP_VEL);
    localparam logic signed [V_W-1:0] MAXF_V  = V_W'(MAX_FALL);
    localparam logic signed [V_W:0]   MAXF_W  = (V_W+1)'(MAX_FALL);
    localparam logic signed [V_W:0]   GRAV_W  = (V_W+1)'(GRAVITY);

    logic                  tick_s;
    logic [P_W-1:0]        pos_r, pos_n_s;
    logic signed [V_W-1:0] vel_r, vel_n_s;
    state_t                state_r, state_n_s;
    logic                  alive_r, game_over_r, go_s;
    logic                  flap_prev_r, flap_pend_r, hit_pend_r;
    logic                  flap_edge_s, flap_now_s, hit_set_s, hit_now_s;
    logic signed [V_W:0]   v_sum_s;
    logic signed [V_W-1:0] v_grav_s, v_play_s;
    logic signed [S_W-1:0] y_grav_s, y_play_s;

    phys_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_s)
    );

    function automatic logic [P_W-1:0] clamp_pos(input logic signed [S_W-1:0] y);
        logic [P_W-1:0] r;
        if (y >= FLOOR_S) begin
            r = FLOOR_S[P_W-1:0];
        end else if (y <= CEIL_S) begin
            r = CEIL_S[P_W-1:0];
        end else begin
            r = y[P_W-1:0];
        end
        return r;
    endfunction

    // An edge on the update cycle itself is honoured by that update.
    assign flap_edge_s = bus.flap_btn & ~flap_prev_r;
    assign flap_now_s  = flap_pend_r | flap_edge_s;
    assign hit_set_s   = bus.hit & (state_r == ST_PLAY);
    assign hit_now_s   = hit_pend_r | hit_set_s;

    // Candidate velocities and positions, gravity-only and flap-aware.
    always_comb begin
        v_sum_s = $signed({vel_r[V_W-1], vel_r}) + GRAV_W;
        if (v_sum_s > MAXF_W) begin
            v_grav_s = MAXF_V;
        end else begin
            v_grav_s = v_sum_s[V_W-1:0];
        end
        if (flap_now_s) begin
            v_play_s = FLAP_V;
        end else begin
            v_play_s = v_grav_s;
        end
        y_grav_s = $signed({2'b00, pos_r}) + $signed({{(S_W-V_W){v_grav_s[V_W-1]}}, v_grav_s});
        y_play_s = $signed({2'b00, pos_r}) + $signed({{(S_W-V_W){v_play_s[V_W-1]}}, v_play_s});
    end

    // Game FSM and physics next-state, evaluated only on tick cycles.
    always_comb begin
        state_n_s = state_r;
        pos_n_s   = pos_r;
        vel_n_s   = vel_r;
        go_s      = 1'b0;
        if (tick_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (flap_now_s) begin
                        state_n_s = ST_PLAY;
                        vel_n_s   = FLAP_V;
                        pos_n_s   = clamp_pos(y_play_s);
                    end else begin
                        state_n_s = ST_IDLE;
                    end
                end
                ST_PLAY: begin
                    if (hit_now_s) begin
                        state_n_s = ST_FALL;
                        vel_n_s   = v_grav_s;
                        pos_n_s   = clamp_pos(y_grav_s);
                    end else if (y_play_s >= FLOOR_S) begin
                        state_n_s = ST_OVER;
                        vel_n_s   = {V_W{1'b0}};
                        pos_n_s   = FLOOR_S[P_W-1:0];
                        go_s      = 1'b1;
                    end else if (y_play_s <= CEIL_S) begin
                        state_n_s = ST_FALL;
                        vel_n_s   = {V_W{1'b0}};
                        pos_n_s   = CEIL_S[P_W-1:0];
                    end else begin
                        vel_n_s   = v_play_s;
                        pos_n_s   = y_play_s[P_W-1:0];
                    end
                end
                ST_FALL: begin
                    if (y_grav_s >= FLOOR_S) begin
                        state_n_s = ST_OVER;
                        vel_n_s   = {V_W{1'b0}};
                        pos_n_s   = FLOOR_S[P_W-1:0];
                        go_s      = 1'b1;
                    end else begin
                        vel_n_s   = v_grav_s;
                        pos_n_s   = clamp_pos(y_grav_s);
                    end
                end
                ST_OVER: begin
                    if (flap_now_s) begin
                        state_n_s = ST_IDLE;
                        vel_n_s   = {V_W{1'b0}};
                        pos_n_s   = START_P;
                    end else begin
                        state_n_s = ST_OVER;
                    end
                end
                default: begin
                    state_n_s = ST_IDLE;
                    vel_n_s   = {V_W{1'b0}};
                    pos_n_s   = START_P;
                end
            endcase
        end else begin
            state_n_s = state_r;
        end
    end

    // State registers plus the flap/hit latches, which clear on every update.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_r       <= START_P;
            vel_r       <= {V_W{1'b0}};
            state_r     <= ST_IDLE;
            alive_r     <= 1'b0;
            game_over_r <= 1'b0;
            flap_prev_r <= 1'b0;
            flap_pend_r <= 1'b0;
            hit_pend_r  <= 1'b0;
        end else begin
            pos_r       <= pos_n_s;
            vel_r       <= vel_n_s;
            state_r     <= state_n_s;
            alive_r     <= is_alive(state_n_s);
            game_over_r <= go_s;
            flap_prev_r <= bus.flap_btn;
            flap_pend_r <= tick_s ? 1'b0 : (flap_pend_r | flap_edge_s);
            hit_pend_r  <= tick_s ? 1'b0 : (hit_pend_r | hit_set_s);
        end
    end

    assign bus.bird_y    = pos_r[P_W-1:FRAC];
    assign bus.velocity  = vel_r;
    assign bus.alive     = alive_r;
    assign bus.state     = state_r;
    assign bus.tick      = tick_s;
    assign bus.game_over = game_over_r;
endmodule

// File: tb/tb_bird_motion_ctrl.sv
// Scoreboard bench for bird_motion_ctrl with TICK_DIV=4: stimulus queues the
// expected post-update outputs, a monitor checks them after every tick.
module tb_bird_motion_ctrl;
    import bird_pkg::*;

    typedef struct {
        string nm;
        int    y;
        int    v;
        int    st;
        int    al;
        int    go;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   go_cnt = 0;
    bit   pend = 1'b0;
    exp_t exp_q[$];
    exp_t mon_e;

    bird_if bus ();

    bird_motion_ctrl #(.TICK_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endfunction

    // Monitor: one negedge after a tick the registered outputs are compared.
    always @(negedge clk) begin
        if (pend && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk({mon_e.nm, ".bird_y"},    int'(bus.bird_y),             mon_e.y);
            chk({mon_e.nm, ".velocity"},  int'($signed(bus.velocity)),  mon_e.v);
            chk({mon_e.nm, ".state"},     int'(bus.state),              mon_e.st);
            chk({mon_e.nm, ".alive"},     int'(bus.alive),              mon_e.al);
            chk({mon_e.nm, ".game_over"}, int'(bus.game_over),          mon_e.go);
        end
        pend = bus.tick && !reset;
        if (bus.game_over) go_cnt++;
    end

    task automatic upd(input string nm, input int y, input int v, input int st,
                       input int al, input int go);
        exp_t e;
        e.nm = nm; e.y = y; e.v = v; e.st = st; e.al = al; e.go = go;
        exp_q.push_back(e);
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) #1;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: pending=%0d expected 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic pulse_flap();
        bus.flap_btn = 1'b1;
        #10;
        bus.flap_btn = 1'b0;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, ".bird_y"},    int'(bus.bird_y), 200);
        chk({nm, ".velocity"},  int'($signed(bus.velocity)), 0);
        chk({nm, ".state"},     int'(bus.state), int'(ST_IDLE));
        chk({nm, ".alive"},     int'(bus.alive), 0);
        chk({nm, ".tick"},      int'(bus.tick), 0);
        chk({nm, ".game_over"}, int'(bus.game_over), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t3y[10] = '{176, 172, 170, 170, 172, 176, 181, 186, 191, 196};
        int t3v[10] = '{-24, -16, -8, 0, 8, 16, 20, 20, 20, 20};
        int h6y[8]  = '{190, 182, 176, 172, 170, 170, 172, 176};
        int h6v[8]  = '{-40, -32, -24, -16, -8, 0, 8, 16};
        int p, v, vv, go_base, n;

        bus.flap_btn = 1'b0;
        bus.hit      = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("t1_reset");
        reset = 1'b0;

        // 1: idle with no inputs
        for (int i = 0; i < 10; i++) upd("t1_idle", 200, 0, int'(ST_IDLE), 0, 0);
        chk("t1_no_game_over", go_cnt, 0);

        // 2: first flap starts play
        pulse_flap();
        upd("t2_flap", 190, -40, int'(ST_PLAY), 1, 0);
        upd("t2_grav", 182, -32, int'(ST_PLAY), 1, 0);

        // 3: gravity ramp with saturation at MAX_FALL
        for (int i = 0; i < 10; i++) upd("t3_ramp", t3y[i], t3v[i], int'(ST_PLAY), 1, 0);

        // 4: free fall to floor, then restart
        p = 784;
        go_base = go_cnt;
        for (int i = 0; i < 100; i++) begin
            if (p + 20 >= 1792) begin
                upd("t4_floor", 448, 0, int'(ST_OVER), 0, 1);
                break;
            end
            p += 20;
            upd("t4_fall", p / 4, 20, int'(ST_PLAY), 1, 0);
        end
        upd("t4_over_hold", 448, 0, int'(ST_OVER), 0, 0);
        upd("t4_over_hold", 448, 0, int'(ST_OVER), 0, 0);
        chk("t4_game_over_once", go_cnt - go_base, 1);
        pulse_flap();
        upd("t4_restart", 200, 0, int'(ST_IDLE), 0, 0);

        // 5: hit with simultaneous flap, then flaps ignored while falling
        pulse_flap();
        upd("t5_play", 190, -40, int'(ST_PLAY), 1, 0);
        bus.hit = 1'b1;
        bus.flap_btn = 1'b1;
        #10;
        bus.hit = 1'b0;
        bus.flap_btn = 1'b0;
        upd("t5_hit", 182, -32, int'(ST_FALL), 0, 0);
        p = 728;
        v = -32;
        go_base = go_cnt;
        for (int i = 0; i < 100; i++) begin
            pulse_flap();
            vv = (v + 8 > 20) ? 20 : v + 8;
            if (p + vv >= 1792) begin
                upd("t5_floor", 448, 0, int'(ST_OVER), 0, 1);
                break;
            end
            p += vv;
            v = vv;
            upd("t5_drop", p / 4, v, int'(ST_FALL), 0, 0);
        end
        upd("t5_over_hold", 448, 0, int'(ST_OVER), 0, 0);
        chk("t5_game_over_once", go_cnt - go_base, 1);

        // 6: held button gives one flap; repeated flaps hit the ceiling
        pulse_flap();
        upd("t6_idle", 200, 0, int'(ST_IDLE), 0, 0);
        bus.flap_btn = 1'b1;
        for (int i = 0; i < 8; i++) upd("t6_hold", h6y[i], h6v[i], int'(ST_PLAY), 1, 0);
        bus.flap_btn = 1'b0;
        #10;
        p = 704;
        for (int i = 0; i < 100; i++) begin
            pulse_flap();
            if (p - 40 <= 0) begin
                upd("t6_ceiling", 0, 0, int'(ST_FALL), 0, 0);
                break;
            end
            p -= 40;
            upd("t6_climb", p / 4, -40, int'(ST_PLAY), 1, 0);
        end
        reset = 1'b1;
        #20;
        chk_reset_vals("t6_reset");
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n++;
            if (bus.tick) break;
        end
        chk("t6_first_tick_latency", n, 3);
        upd("t6_post_reset", 200, 0, int'(ST_IDLE), 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
